// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encoding, byte-lane masks and load
// result extension. Functions work at a fixed 64-bit width; callers truncate
// to their own XLEN.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_t;

  // Bytes touched by an access of the given size at the given byte offset.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (mem_size_t'(size))
      MEM_B:   base = 8'h01;
      MEM_H:   base = 8'h03;
      MEM_W:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Sign- or zero-extend the low bytes of an already right-aligned value.
  function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [1:0] size,
                                              input logic is_unsigned);
    logic [63:0] result;
    case (mem_size_t'(size))
      MEM_B:   result = {{56{~is_unsigned & data[7]}}, data[7:0]};
      MEM_H:   result = {{48{~is_unsigned & data[15]}}, data[15:0]};
      MEM_W:   result = {{32{~is_unsigned & data[31]}}, data[31:0]};
      default: result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_entry_select.sv
// Circular-queue age selectors. Age of an entry is (index - head) mod SIZE,
// so head = SIZE-1 wraps naturally.

module youngest_entry_select #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0]         req,
  input  logic [$clog2(SIZE)-1:0] head,
  output logic                    found,
  output logic [$clog2(SIZE)-1:0] idx
);
  localparam int IW = $clog2(SIZE);
  logic [IW-1:0] e;

  // Walk from oldest to youngest; the last requester seen is the youngest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    e     = '0;
    for (int k = 0; k < SIZE; k++) begin
      e = IW'((int'(head) + k) % SIZE);
      if (req[e]) begin
        found = 1'b1;
        idx   = e;
      end
    end
  end
endmodule

module oldest_entry_select #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0]         req,
  input  logic [$clog2(SIZE)-1:0] head,
  output logic                    found,
  output logic [$clog2(SIZE)-1:0] idx
);
  localparam int IW = $clog2(SIZE);
  logic [IW-1:0] e;

  // Walk from youngest to oldest; the last requester seen is the oldest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    e     = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      e = IW'((int'(head) + k) % SIZE);
      if (req[e]) begin
        found = 1'b1;
        idx   = e;
      end
    end
  end
endmodule

// File: rtl/lsu_overlap_match.sv
// Byte-overlap comparator between access A and access B. 'covered' says
// every byte of A is also written by B (only meaningful when overlapping).
module lsu_overlap_match
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_addr,
  input  logic [1:0]      a_size,
  input  logic [XLEN-1:0] b_addr,
  input  logic [1:0]      b_size,
  output logic            overlap,
  output logic            covered
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);

  logic [NB-1:0] a_mask;
  logic [NB-1:0] b_mask;
  logic          same_word;

  assign a_mask    = NB'(byte_mask(a_size, 3'(a_addr[OFF-1:0])));
  assign b_mask    = NB'(byte_mask(b_size, 3'(b_addr[OFF-1:0])));
  assign same_word = (a_addr[XLEN-1:OFF] == b_addr[XLEN-1:OFF]);
  assign overlap   = same_word & (|(a_mask & b_mask));
  assign covered   = ~|(a_mask & ~b_mask);
endmodule

// File: rtl/lsu_searcher_pipelined.sv
// LSU searcher: LD_PORTS load channels search older stores for forwarding
// or sleep, and one store channel detects younger loads that already read
// stale data. All outputs are registered one cycle after the request.
module lsu_searcher_pipelined
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 32,
  parameter int STQ_SIZE      = 32,
  parameter int LD_PORTS      = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic [LDQ_SIZE-1:0]                       ldq_valid,
  input  logic [LDQ_SIZE-1:0][XLEN-1:0]             ldq_address,
  input  logic [LDQ_SIZE-1:0]                       ldq_address_valid,
  input  logic [LDQ_SIZE-1:0]                       ldq_executed,
  input  logic [LDQ_SIZE-1:0][1:0]                  ldq_size,
  input  logic [LDQ_SIZE-1:0]                       ldq_unsigned,
  input  logic [LDQ_SIZE-1:0][STQ_SIZE-1:0]         ldq_store_mask,
  input  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]    ldq_rob_tag,
  input  logic [$clog2(LDQ_SIZE)-1:0]               ldq_head,
  input  logic [STQ_SIZE-1:0]                       stq_valid,
  input  logic [STQ_SIZE-1:0]                       stq_address_valid,
  input  logic [STQ_SIZE-1:0]                       stq_data_valid,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]             stq_address,
  input  logic [STQ_SIZE-1:0][1:0]                  stq_size,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]             stq_data,
  input  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]    stq_rob_tag,
  input  logic [$clog2(STQ_SIZE)-1:0]               stq_head,
  input  logic [LD_PORTS-1:0]                       load_fired,
  input  logic [LD_PORTS-1:0][$clog2(LDQ_SIZE)-1:0] load_fired_ldq_index,
  input  logic                                      store_check_valid,
  input  logic [$clog2(STQ_SIZE)-1:0]               store_check_stq_index,
  input  logic [XLEN-1:0]                           store_check_address,
  output logic [LD_PORTS-1:0]                       resp_valid,
  output logic [LD_PORTS-1:0]                       kill_mem_req,
  output logic [LD_PORTS-1:0]                       forward,
  output logic [LD_PORTS-1:0]                       sleep,
  output logic [LD_PORTS-1:0][$clog2(LDQ_SIZE)-1:0] resp_ldq_index,
  output logic [LD_PORTS-1:0][XLEN-1:0]             forward_data,
  output logic [LD_PORTS-1:0][$clog2(STQ_SIZE)-1:0] stq_forward_index,
  output logic [LD_PORTS-1:0][ROB_TAG_WIDTH-1:0]    sleep_rob_tag,
  output logic                                      order_fail,
  output logic [ROB_TAG_WIDTH-1:0]                  order_fail_rob_tag
);
  localparam int LIW = $clog2(LDQ_SIZE);
  localparam int SIW = $clog2(STQ_SIZE);
  localparam int OFF = $clog2(XLEN / 8);

  logic [LD_PORTS-1:0]                    kill_nxt, forward_nxt, sleep_nxt;
  logic [LD_PORTS-1:0][LIW-1:0]           lidx_nxt;
  logic [LD_PORTS-1:0][XLEN-1:0]          fdata_nxt;
  logic [LD_PORTS-1:0][SIW-1:0]           fidx_nxt;
  logic [LD_PORTS-1:0][ROB_TAG_WIDTH-1:0] stag_nxt;

  // Loads issuing this cycle count as executed for the store ordering check.
  logic [LDQ_SIZE-1:0] fired_any;
  always_comb begin
    fired_any = '0;
    for (int p = 0; p < LD_PORTS; p++) begin
      if (load_fired[p]) fired_any[load_fired_ldq_index[p]] = 1'b1;
    end
  end

  for (genvar p = 0; p < LD_PORTS; p++) begin : g_port
    logic [LIW-1:0]      lidx;
    logic [STQ_SIZE-1:0] ovl, cov, hit;
    logic                found, fwd_ok;
    logic [SIW-1:0]      sel;
    logic [OFF-1:0]      st_off, ld_off;
    logic [XLEN-1:0]     aligned;

    assign lidx = load_fired_ldq_index[p];

    for (genvar s = 0; s < STQ_SIZE; s++) begin : g_stq
      lsu_overlap_match #(.XLEN(XLEN)) u_match (
        .a_addr (ldq_address[lidx]),
        .a_size (ldq_size[lidx]),
        .b_addr (stq_address[s]),
        .b_size (stq_size[s]),
        .overlap(ovl[s]),
        .covered(cov[s])
      );
      assign hit[s] = load_fired[p] & ldq_store_mask[lidx][s] & stq_valid[s]
                    & stq_address_valid[s] & ovl[s];
    end

    youngest_entry_select #(.SIZE(STQ_SIZE)) u_young (
      .req  (hit),
      .head (stq_head),
      .found(found),
      .idx  (sel)
    );

    // Store data is register-aligned: move it to its memory lane, then down
    // to the load's lane before extension.
    assign st_off  = stq_address[sel][OFF-1:0];
    assign ld_off  = ldq_address[lidx][OFF-1:0];
    assign aligned = (stq_data[sel] << {st_off, 3'b000}) >> {ld_off, 3'b000};
    assign fwd_ok  = found & cov[sel] & stq_data_valid[sel];

    assign kill_nxt[p]    = found;
    assign forward_nxt[p] = fwd_ok;
    assign sleep_nxt[p]   = found & ~fwd_ok;
    assign lidx_nxt[p]    = load_fired[p] ? lidx : '0;
    assign fidx_nxt[p]    = fwd_ok ? sel : '0;
    assign stag_nxt[p]    = (found & ~fwd_ok) ? stq_rob_tag[sel] : '0;
    assign fdata_nxt[p]   = fwd_ok ? XLEN'(load_extend(64'(aligned), ldq_size[lidx],
                                                       ldq_unsigned[lidx])) : '0;
  end

  logic [LDQ_SIZE-1:0] cand, ld_ovl, ld_cov_unused;
  logic                of_found;
  logic [LIW-1:0]      of_sel;

  for (genvar j = 0; j < LDQ_SIZE; j++) begin : g_ldq
    lsu_overlap_match #(.XLEN(XLEN)) u_match (
      .a_addr (ldq_address[j]),
      .a_size (ldq_size[j]),
      .b_addr (store_check_address),
      .b_size (stq_size[store_check_stq_index]),
      .overlap(ld_ovl[j]),
      .covered(ld_cov_unused[j])
    );
    assign cand[j] = store_check_valid & ldq_valid[j] & ldq_address_valid[j]
                   & ~ldq_store_mask[j][store_check_stq_index]
                   & (ldq_executed[j] | fired_any[j]) & ld_ovl[j];
  end

  oldest_entry_select #(.SIZE(LDQ_SIZE)) u_oldest (
    .req  (cand),
    .head (ldq_head),
    .found(of_found),
    .idx  (of_sel)
  );

  // Response registers; flush drops everything requested in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      resp_valid         <= '0;
      kill_mem_req       <= '0;
      forward            <= '0;
      sleep              <= '0;
      resp_ldq_index     <= '0;
      forward_data       <= '0;
      stq_forward_index  <= '0;
      sleep_rob_tag      <= '0;
      order_fail         <= 1'b0;
      order_fail_rob_tag <= '0;
    end else begin
      resp_valid         <= load_fired;
      kill_mem_req       <= kill_nxt;
      forward            <= forward_nxt;
      sleep              <= sleep_nxt;
      resp_ldq_index     <= lidx_nxt;
      forward_data       <= fdata_nxt;
      stq_forward_index  <= fidx_nxt;
      sleep_rob_tag      <= stag_nxt;
      order_fail         <= of_found;
      order_fail_rob_tag <= of_found ? ldq_rob_tag[of_sel] : '0;
    end
  end
endmodule

// File: tb/tb_lsu_searcher_pipelined.sv
// Self-checking bench for lsu_searcher_pipelined: a table of single
// store/load forwarding cases plus short sequences for age wrap, store
// ordering, flush and asynchronous reset. Expected responses are queued when
// stimulus is driven and compared one cycle later.
module tb_lsu_searcher_pipelined;
  localparam int XL = 32, RTW = 32, LQ = 32, SQ = 32, LP = 2;

  logic clk, reset, flush;
  logic [LQ-1:0]          ldq_valid, ldq_address_valid, ldq_executed, ldq_unsigned;
  logic [LQ-1:0][XL-1:0]  ldq_address;
  logic [LQ-1:0][1:0]     ldq_size;
  logic [LQ-1:0][SQ-1:0]  ldq_store_mask;
  logic [LQ-1:0][RTW-1:0] ldq_rob_tag;
  logic [4:0]             ldq_head, stq_head;
  logic [SQ-1:0]          stq_valid, stq_address_valid, stq_data_valid;
  logic [SQ-1:0][XL-1:0]  stq_address, stq_data;
  logic [SQ-1:0][1:0]     stq_size;
  logic [SQ-1:0][RTW-1:0] stq_rob_tag;
  logic [LP-1:0]          load_fired;
  logic [LP-1:0][4:0]     load_fired_ldq_index;
  logic                   store_check_valid;
  logic [4:0]             store_check_stq_index;
  logic [XL-1:0]          store_check_address;
  logic [LP-1:0]          resp_valid, kill_mem_req, forward, sleep;
  logic [LP-1:0][4:0]     resp_ldq_index, stq_forward_index;
  logic [LP-1:0][XL-1:0]  forward_data;
  logic [LP-1:0][RTW-1:0] sleep_rob_tag;
  logic                   order_fail;
  logic [RTW-1:0]         order_fail_rob_tag;

  lsu_searcher_pipelined #(
    .XLEN(XL), .ROB_TAG_WIDTH(RTW), .LDQ_SIZE(LQ), .STQ_SIZE(SQ), .LD_PORTS(LP)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ldq_valid(ldq_valid), .ldq_address(ldq_address), .ldq_address_valid(ldq_address_valid),
    .ldq_executed(ldq_executed), .ldq_size(ldq_size), .ldq_unsigned(ldq_unsigned),
    .ldq_store_mask(ldq_store_mask), .ldq_rob_tag(ldq_rob_tag), .ldq_head(ldq_head),
    .stq_valid(stq_valid), .stq_address_valid(stq_address_valid),
    .stq_data_valid(stq_data_valid), .stq_address(stq_address), .stq_size(stq_size),
    .stq_data(stq_data), .stq_rob_tag(stq_rob_tag), .stq_head(stq_head),
    .load_fired(load_fired), .load_fired_ldq_index(load_fired_ldq_index),
    .store_check_valid(store_check_valid), .store_check_stq_index(store_check_stq_index),
    .store_check_address(store_check_address),
    .resp_valid(resp_valid), .kill_mem_req(kill_mem_req), .forward(forward), .sleep(sleep),
    .resp_ldq_index(resp_ldq_index), .forward_data(forward_data),
    .stq_forward_index(stq_forward_index), .sleep_rob_tag(sleep_rob_tag),
    .order_fail(order_fail), .order_fail_rob_tag(order_fail_rob_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LP-1:0]          rv, kl, fw, sl;
    logic [LP-1:0][4:0]     li, si;
    logic [LP-1:0][31:0]    fd, tg;
    logic                   of;
    logic [31:0]            oft;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] la;
    logic [1:0]  lsz;
    logic        lu;
    logic [31:0] sa;
    logic [1:0]  ssz;
    logic [31:0] sd;
    logic        dv;
    logic        mk;
    int          kind;   // 0 no match, 1 forward, 2 sleep
    logic [31:0] ed;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.rv = '0; e.kl = '0; e.fw = '0; e.sl = '0;
    e.li = '0; e.si = '0; e.fd = '0; e.tg = '0;
    e.of = 1'b0; e.oft = '0;
    return e;
  endfunction

  function automatic exp_t with_resp(input exp_t e0, input logic p, input logic [4:0] li,
                                     input int kind, input logic [4:0] si,
                                     input logic [31:0] d, input logic [31:0] t);
    exp_t e;
    e = e0;
    e.rv[p] = 1'b1;
    e.li[p] = li;
    e.kl[p] = (kind != 0);
    e.fw[p] = (kind == 1);
    e.sl[p] = (kind == 2);
    if (kind == 1) begin
      e.si[p] = si;
      e.fd[p] = d;
    end
    if (kind == 2) e.tg[p] = t;
    return e;
  endfunction

  task automatic compare_head(input string nm);
    exp_t e;
    logic pi;
    e = q.pop_front();
    for (int p = 0; p < LP; p++) begin
      pi = p[0];
      check($sformatf("%s.p%0d.resp_valid", nm, p), resp_valid[pi], e.rv[pi]);
      check($sformatf("%s.p%0d.kill", nm, p), kill_mem_req[pi], e.kl[pi]);
      check($sformatf("%s.p%0d.forward", nm, p), forward[pi], e.fw[pi]);
      check($sformatf("%s.p%0d.sleep", nm, p), sleep[pi], e.sl[pi]);
      check($sformatf("%s.p%0d.ldq_index", nm, p), resp_ldq_index[pi], e.li[pi]);
      check($sformatf("%s.p%0d.fwd_data", nm, p), forward_data[pi], e.fd[pi]);
      check($sformatf("%s.p%0d.stq_index", nm, p), stq_forward_index[pi], e.si[pi]);
      check($sformatf("%s.p%0d.sleep_tag", nm, p), sleep_rob_tag[pi], e.tg[pi]);
    end
    check($sformatf("%s.order_fail", nm), order_fail, e.of);
    check($sformatf("%s.order_tag", nm), order_fail_rob_tag, e.oft);
  endtask

  // Queue the expectation, let the DUT register it, compare after the edge.
  task automatic step(input string nm, input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_head(nm);
  endtask

  task automatic clear_all();
    flush = 1'b0;
    ldq_valid = '0; ldq_address_valid = '0; ldq_executed = '0; ldq_unsigned = '0;
    ldq_address = '0; ldq_size = '0; ldq_store_mask = '0; ldq_rob_tag = '0; ldq_head = '0;
    stq_valid = '0; stq_address_valid = '0; stq_data_valid = '0; stq_address = '0;
    stq_size = '0; stq_data = '0; stq_rob_tag = '0; stq_head = '0;
    load_fired = '0; load_fired_ldq_index = '0;
    store_check_valid = 1'b0; store_check_stq_index = '0; store_check_address = '0;
  endtask

  task automatic set_store(input logic [4:0] s, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d, input logic dv, input logic [31:0] tag);
    stq_valid[s] = 1'b1; stq_address_valid[s] = 1'b1; stq_address[s] = a;
    stq_size[s] = sz; stq_data[s] = d; stq_data_valid[s] = dv; stq_rob_tag[s] = tag;
  endtask

  task automatic set_load(input logic [4:0] j, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic ex, input logic [31:0] tag);
    ldq_valid[j] = 1'b1; ldq_address_valid[j] = 1'b1; ldq_address[j] = a;
    ldq_size[j] = sz; ldq_unsigned[j] = u; ldq_executed[j] = ex; ldq_rob_tag[j] = tag;
  endtask

  vec_t tbl[14];
  exp_t e;

  initial begin
    tbl[0]  = '{"lb_signed",    32'h102, 2'd0, 1'b0, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b1, 1, 32'hFFFFFF99};
    tbl[1]  = '{"lb_unsigned",  32'h102, 2'd0, 1'b1, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b1, 1, 32'h00000099};
    tbl[2]  = '{"lh_signed",    32'h102, 2'd1, 1'b0, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b1, 1, 32'hFFFF8899};
    tbl[3]  = '{"lw_full",      32'h100, 2'd2, 1'b0, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b1, 1, 32'h8899AABB};
    tbl[4]  = '{"lh_unsigned",  32'h100, 2'd1, 1'b1, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b1, 1, 32'h0000AABB};
    tbl[5]  = '{"sb_lb_shift",  32'h203, 2'd0, 1'b0, 32'h203,  2'd0, 32'h000000C7, 1'b1, 1'b1, 1, 32'hFFFFFFC7};
    tbl[6]  = '{"sh_lb_inner",  32'h103, 2'd0, 1'b1, 32'h102,  2'd1, 32'h00001234, 1'b1, 1'b1, 1, 32'h00000012};
    tbl[7]  = '{"sb_lw_part",   32'h200, 2'd2, 1'b0, 32'h203,  2'd0, 32'h000000C7, 1'b1, 1'b1, 2, 32'h0};
    tbl[8]  = '{"sb_lw_nodata", 32'h200, 2'd2, 1'b0, 32'h203,  2'd0, 32'h000000C7, 1'b0, 1'b1, 2, 32'h0};
    tbl[9]  = '{"sw_lb_nodata", 32'h101, 2'd0, 1'b0, 32'h100,  2'd2, 32'h8899AABB, 1'b0, 1'b1, 2, 32'h0};
    tbl[10] = '{"next_word",    32'h104, 2'd2, 1'b0, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b1, 0, 32'h0};
    tbl[11] = '{"disjoint_h",   32'h102, 2'd1, 1'b0, 32'h100,  2'd1, 32'h00001234, 1'b1, 1'b1, 0, 32'h0};
    tbl[12] = '{"mask_clear",   32'h100, 2'd2, 1'b0, 32'h100,  2'd2, 32'h8899AABB, 1'b1, 1'b0, 0, 32'h0};
    tbl[13] = '{"high_addr",    32'h100, 2'd2, 1'b0, 32'h1100, 2'd2, 32'h8899AABB, 1'b1, 1'b1, 0, 32'h0};

    clear_all();
    reset = 1'b1;
    #12;
    q.push_back(blank());
    compare_head("reset_state");
    reset = 1'b0;

    // Single store s1 (tag 0x51), single load j3 on port 0.
    for (int i = 0; i < 14; i++) begin
      clear_all();
      set_store(5'd1, tbl[i].sa, tbl[i].ssz, tbl[i].sd, tbl[i].dv, 32'h51);
      set_load(5'd3, tbl[i].la, tbl[i].lsz, tbl[i].lu, 1'b0, 32'h303);
      ldq_store_mask[3][1] = tbl[i].mk;
      load_fired = 2'b01;
      load_fired_ldq_index[0] = 5'd3;
      step(tbl[i].nm, with_resp(blank(), 1'b0, 5'd3, tbl[i].kind, 5'd1, tbl[i].ed, 32'h51));
    end

    // Youngest-store selection with wrap around stq_head.
    clear_all();
    set_store(5'd3, 32'h40, 2'd2, 32'h33333333, 1'b1, 32'h63);
    set_store(5'd5, 32'h40, 2'd2, 32'h55555555, 1'b1, 32'h65);
    set_load(5'd2, 32'h40, 2'd2, 1'b1, 1'b0, 32'h202);
    ldq_store_mask[2][3] = 1'b1;
    ldq_store_mask[2][5] = 1'b1;
    load_fired = 2'b01;
    load_fired_ldq_index[0] = 5'd2;
    stq_head = 5'd6;
    step("young_head6", with_resp(blank(), 1'b0, 5'd2, 1, 5'd5, 32'h55555555, 32'h0));
    stq_head = 5'd4;
    step("young_head4_wrap", with_resp(blank(), 1'b0, 5'd2, 1, 5'd3, 32'h33333333, 32'h0));
    ldq_store_mask[2][3] = 1'b0;
    step("young_s3_masked", with_resp(blank(), 1'b0, 5'd2, 1, 5'd5, 32'h55555555, 32'h0));
    ldq_store_mask[2][3] = 1'b1;
    stq_head = 5'd31;
    step("young_head_max", with_resp(blank(), 1'b0, 5'd2, 1, 5'd5, 32'h55555555, 32'h0));
    stq_head = 5'd6;
    stq_data_valid[5] = 1'b0;
    step("young_sleeps", with_resp(blank(), 1'b0, 5'd2, 2, 5'd0, 32'h0, 32'h65));
    stq_data_valid[5] = 1'b1;
    load_fired = 2'b11;
    load_fired_ldq_index[1] = 5'd2;
    e = with_resp(blank(), 1'b0, 5'd2, 1, 5'd5, 32'h55555555, 32'h0);
    e = with_resp(e, 1'b1, 5'd2, 1, 5'd5, 32'h55555555, 32'h0);
    step("dual_port_same", e);

    // Store-check ordering: oldest younger executed load relative to ldq_head.
    clear_all();
    stq_size[2] = 2'd2;
    set_load(5'd7, 32'h80, 2'd2, 1'b0, 1'b1, 32'h707);
    set_load(5'd9, 32'h80, 2'd2, 1'b0, 1'b1, 32'h909);
    store_check_valid = 1'b1;
    store_check_stq_index = 5'd2;
    store_check_address = 32'h80;
    ldq_head = 5'd5;
    e = blank(); e.of = 1'b1; e.oft = 32'h707;
    step("order_head5", e);
    ldq_head = 5'd8;
    e = blank(); e.of = 1'b1; e.oft = 32'h909;
    step("order_head8_wrap", e);
    ldq_head = 5'd5;
    ldq_store_mask[7][2] = 1'b1;
    step("order_j7_older", e);
    ldq_store_mask[7][2] = 1'b0;
    store_check_address = 32'h84;
    step("order_no_overlap", blank());
    stq_size[2] = 2'd0;
    store_check_address = 32'h83;
    e = blank(); e.of = 1'b1; e.oft = 32'h707;
    step("order_byte_store", e);
    stq_size[2] = 2'd2;
    store_check_address = 32'h80;
    ldq_executed = '0;
    load_fired = 2'b10;
    load_fired_ldq_index[1] = 5'd9;
    e = with_resp(blank(), 1'b1, 5'd9, 0, 5'd0, 32'h0, 32'h0);
    e.of = 1'b1; e.oft = 32'h909;
    step("order_fired_now", e);
    store_check_valid = 1'b0;
    load_fired = '0;
    step("order_one_cycle", blank());

    // Both ports plus a store check, first without and then with flush.
    clear_all();
    set_store(5'd1, 32'h100, 2'd2, 32'h8899AABB, 1'b1, 32'h51);
    set_load(5'd3, 32'h102, 2'd0, 1'b0, 1'b0, 32'h303);
    ldq_store_mask[3][1] = 1'b1;
    set_load(5'd7, 32'h100, 2'd2, 1'b0, 1'b1, 32'h707);
    load_fired = 2'b11;
    load_fired_ldq_index[0] = 5'd3;
    load_fired_ldq_index[1] = 5'd3;
    store_check_valid = 1'b1;
    store_check_stq_index = 5'd1;
    store_check_address = 32'h100;
    e = with_resp(blank(), 1'b0, 5'd3, 1, 5'd1, 32'hFFFFFF99, 32'h0);
    e = with_resp(e, 1'b1, 5'd3, 1, 5'd1, 32'hFFFFFF99, 32'h0);
    e.of = 1'b1; e.oft = 32'h707;
    step("no_flush", e);
    flush = 1'b1;
    step("flush", blank());
    flush = 1'b0;
    step("after_flush", e);

    // Reset between clock edges must clear outputs without waiting for clk.
    #2;
    reset = 1'b1;
    #1;
    q.push_back(blank());
    compare_head("async_reset");
    #2;
    reset = 1'b0;
    step("after_reset", e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
